// File: rtl/music_seq_ctl.sv
// Score sequencer: walks an external score ROM at a selectable tempo and drives tone-generator divisors.
// Optional HARMONY_EN: left channel one octave below the right instead of mono.
module music_seq_ctl #(
    parameter int ADDR_W   = 6,
    parameter int BEAT_CYC = 25_000_000,
    parameter int GAP_CYC  = 1_000_000
) (
    input  logic              clk_100mhz,
    input  logic              rst_n,
    input  logic              start,
    input  logic              pause,
    input  logic              stop,
    input  logic              loop_en,
    input  logic [1:0]        tempo,
    input  logic [3:0]        score_letter,
    input  logic [1:0]        score_octave,
    output logic [ADDR_W-1:0] score_addr,
    output logic [21:0]       note_div_right,
    output logic [21:0]       note_div_left,
    output logic [3:0]        letter,
    output logic              playing,
    output logic              done
);
    localparam int BC_W = $clog2(BEAT_CYC + 1);
    localparam logic [BC_W-1:0] BEAT_L = BC_W'(BEAT_CYC);
    localparam logic [BC_W-1:0] GAP_L  = BC_W'(GAP_CYC);
    localparam logic [21:0]     DIV_RST = 22'd191109;

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_PAUSE} state_t;

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [BC_W-1:0]   r_bc, w_bc_nxt;
    logic              r_done, w_done_nxt;
    logic [3:0]        r_letter;
    logic [21:0]       r_div_r, r_div_l;

    logic [BC_W-1:0]   w_beat_len;
    logic              w_last, w_win, w_is_note, w_is_end, w_sound;
    logic [17:0]       w_base;
    logic [21:0]       w_half;

    assign w_beat_len = BEAT_L >> tempo;
    // >= (not ==) so a tempo speed-up past the current count still ends the step
    assign w_last     = (r_bc >= (w_beat_len - BC_W'(1)));
    assign w_win      = (r_bc < (w_beat_len - GAP_L));
    assign w_is_note  = (score_letter >= 4'd1) && (score_letter <= 4'd7);
    assign w_is_end   = (score_letter == 4'd15);

    always_comb begin
        w_base = 18'd191110;
        case (score_letter[2:0])
            3'd1:    w_base = 18'd191110;
            3'd2:    w_base = 18'd170265;
            3'd3:    w_base = 18'd151685;
            3'd4:    w_base = 18'd143172;
            3'd5:    w_base = 18'd127551;
            3'd6:    w_base = 18'd113636;
            3'd7:    w_base = 18'd101239;
            default: w_base = 18'd191110;
        endcase
    end

    always_comb begin
        w_half = 22'(w_base);
        case (score_octave)
            2'd0:    w_half = 22'(w_base) << 1;
            2'd1:    w_half = 22'(w_base);
            2'd2:    w_half = 22'(w_base) >> 1;
            default: w_half = 22'(w_base) >> 2;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_bc_nxt    = r_bc;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (stop) begin
                    w_addr_nxt = '0;
                    w_bc_nxt   = '0;
                end else if (start) begin
                    w_state_nxt = S_PLAY;
                    w_addr_nxt  = '0;
                    w_bc_nxt    = '0;
                end
            end
            S_PLAY: begin
                if (stop) begin
                    w_state_nxt = S_IDLE;
                    w_addr_nxt  = '0;
                    w_bc_nxt    = '0;
                end else if (pause) begin
                    w_state_nxt = S_PAUSE;
                end else if (w_is_end && (r_bc == '0)) begin
                    // end marker costs one cycle; bc stays 0 for the next step
                    w_addr_nxt = '0;
                    if (!loop_en) begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end else if (w_last) begin
                    w_addr_nxt = r_addr + ADDR_W'(1);
                    w_bc_nxt   = '0;
                end else begin
                    w_bc_nxt = r_bc + BC_W'(1);
                end
            end
            S_PAUSE: begin
                if (stop) begin
                    w_state_nxt = S_IDLE;
                    w_addr_nxt  = '0;
                    w_bc_nxt    = '0;
                end else if (pause || start) begin
                    w_state_nxt = S_PLAY;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_addr_nxt  = '0;
                w_bc_nxt    = '0;
            end
        endcase
    end

    // Only sound while staying in PLAY, so stop/pause silence the output on the same edge
    assign w_sound = (r_state == S_PLAY) && (w_state_nxt == S_PLAY) && w_is_note && w_win;

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_bc     <= '0;
            r_done   <= 1'b0;
            r_letter <= 4'd0;
            r_div_r  <= DIV_RST;
            r_div_l  <= DIV_RST;
        end else begin
            r_state  <= w_state_nxt;
            r_addr   <= w_addr_nxt;
            r_bc     <= w_bc_nxt;
            r_done   <= w_done_nxt;
            r_letter <= w_sound ? score_letter : 4'd0;
            if (w_sound) begin
                r_div_r <= w_half - 22'd1;
`ifdef HARMONY_EN
                r_div_l <= (w_half << 1) - 22'd1;
`else
                r_div_l <= w_half - 22'd1;
`endif
            end
        end
    end

    assign score_addr     = r_addr;
    assign note_div_right = r_div_r;
    assign note_div_left  = r_div_l;
    assign letter         = r_letter;
    assign playing        = (r_state == S_PLAY);
    assign done           = r_done;
endmodule

// File: tb/tb_music_seq_ctl.sv
// Directed bench for music_seq_ctl with a 4-entry behavioural score ROM, BEAT_CYC=16, GAP_CYC=2.
module tb_music_seq_ctl;
    localparam int AW = 6;

    logic          clk_100mhz = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0, pause = 1'b0, stop = 1'b0, loop_en = 1'b0;
    logic [1:0]    tempo = 2'd0;
    logic [3:0]    score_letter;
    logic [1:0]    score_octave;
    logic [AW-1:0] score_addr;
    logic [21:0]   note_div_right, note_div_left;
    logic [3:0]    letter;
    logic          playing, done;

    logic [3:0] rom_l [4];
    logic [1:0] rom_o [4];

    int n_chk  = 0;
    int n_fail = 0;

    music_seq_ctl #(.ADDR_W(AW), .BEAT_CYC(16), .GAP_CYC(2)) dut (
        .clk_100mhz(clk_100mhz), .rst_n(rst_n), .start(start), .pause(pause), .stop(stop),
        .loop_en(loop_en), .tempo(tempo), .score_letter(score_letter), .score_octave(score_octave),
        .score_addr(score_addr), .note_div_right(note_div_right), .note_div_left(note_div_left),
        .letter(letter), .playing(playing), .done(done)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    assign score_letter = (score_addr < AW'(4)) ? rom_l[score_addr[1:0]] : 4'd15;
    assign score_octave = (score_addr < AW'(4)) ? rom_o[score_addr[1:0]] : 2'd0;

    typedef struct {
        int pulse;      // 0 none, 1 start, 2 pause, 3 stop
        int adv;        // cycles advanced, including the pulse cycle
        int exp_play;
        int exp_addr;
        int exp_letter;
        int exp_div;
        int exp_done;
    } vec_t;

    typedef struct {
        int l;
        int o;
        int half;
    } div_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_100mhz);
    endtask

    task automatic pulse(input int kind);
        start = (kind == 1);
        pause = (kind == 2);
        stop  = (kind == 3);
        cyc(1);
        start = 1'b0;
        pause = 1'b0;
        stop  = 1'b0;
    endtask

    function automatic int left_exp(input int half);
`ifdef HARMONY_EN
        return 2 * half - 1;
`else
        return half - 1;
`endif
    endfunction

    task automatic rom_default();
        rom_l[0] = 4'd1;  rom_o[0] = 2'd1;
        rom_l[1] = 4'd5;  rom_o[1] = 2'd1;
        rom_l[2] = 4'd15; rom_o[2] = 2'd0;
        rom_l[3] = 4'd15; rom_o[3] = 2'd0;
    endtask

    initial begin
        vec_t vecs[9];
        div_t dvec[8];
        int   tlet[5];
        logic seen_bad;
        logic seen_done;
        int   last_half;

        rom_default();
        vecs[0] = '{1,  1, 1, 0, 0, 191109, 0};
        vecs[1] = '{0,  1, 1, 0, 1, 191109, 0};
        vecs[2] = '{0, 13, 1, 0, 1, 191109, 0};
        vecs[3] = '{0,  1, 1, 0, 0, 191109, 0};
        vecs[4] = '{0,  1, 1, 1, 0, 191109, 0};
        vecs[5] = '{0,  1, 1, 1, 5, 127550, 0};
        vecs[6] = '{0, 15, 1, 2, 0, 127550, 0};
        vecs[7] = '{0,  1, 0, 0, 0, 127550, 1};
        vecs[8] = '{0,  1, 0, 0, 0, 127550, 0};

        dvec[0] = '{1, 1, 191110};
        dvec[1] = '{5, 1, 127551};
        dvec[2] = '{6, 2, 56818};
        dvec[3] = '{1, 0, 382220};
        dvec[4] = '{7, 3, 25309};
        dvec[5] = '{3, 2, 75842};
        dvec[6] = '{2, 0, 340530};
        dvec[7] = '{4, 3, 35793};

        tlet = '{1, 1, 0, 0, 5};

        cyc(3);
        rst_n = 1'b1;
        cyc(2);
        chk("rst_addr", 32'(score_addr), 0);
        chk("rst_div_r", 32'(note_div_right), 191109);
        chk("rst_div_l", 32'(note_div_left), 191109);
        chk("rst_letter", 32'(letter), 0);
        chk("rst_playing", 32'(playing), 0);
        chk("rst_done", 32'(done), 0);

        // basic score, no loop
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].pulse != 0) begin
                pulse(vecs[i].pulse);
                cyc(vecs[i].adv - 1);
            end else begin
                cyc(vecs[i].adv);
            end
            chk($sformatf("v%0d_playing", i), 32'(playing), vecs[i].exp_play);
            chk($sformatf("v%0d_addr", i), 32'(score_addr), vecs[i].exp_addr);
            chk($sformatf("v%0d_letter", i), 32'(letter), vecs[i].exp_letter);
            chk($sformatf("v%0d_div", i), 32'(note_div_right), vecs[i].exp_div);
            chk($sformatf("v%0d_done", i), 32'(done), vecs[i].exp_done);
        end

        // looping wraps to step 0 through a one-cycle marker
        loop_en = 1'b1;
        pulse(1);
        seen_done = 1'b0;
        for (int i = 0; i < 32; i++) begin
            cyc(1);
            if (done) seen_done = 1'b1;
        end
        chk("loop_addr_marker", 32'(score_addr), 2);
        cyc(1);
        chk("loop_addr_wrap", 32'(score_addr), 0);
        chk("loop_playing", 32'(playing), 1);
        cyc(1);
        chk("loop_letter", 32'(letter), 1);
        for (int i = 0; i < 40; i++) begin
            cyc(1);
            if (done) seen_done = 1'b1;
        end
        chk("loop_no_done", 32'(seen_done), 0);
        pulse(3);
        loop_en = 1'b0;

        // stop and pause together mid-score
        pulse(1);
        cyc(19);
        chk("sp_pre_addr", 32'(score_addr), 1);
        stop  = 1'b1;
        pause = 1'b1;
        cyc(1);
        stop  = 1'b0;
        pause = 1'b0;
        chk("sp_playing", 32'(playing), 0);
        chk("sp_addr", 32'(score_addr), 0);
        chk("sp_letter", 32'(letter), 0);

        // pause at bc=5, hold, resume for 11 more cycles
        pulse(1);
        cyc(5);
        pulse(2);
        chk("pz_playing", 32'(playing), 0);
        chk("pz_letter", 32'(letter), 0);
        seen_bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (letter != 4'd0 || score_addr != '0 || playing) seen_bad = 1'b1;
        end
        chk("pz_hold", 32'(seen_bad), 0);
        pulse(2);
        chk("pz_resume_playing", 32'(playing), 1);
        cyc(1);
        chk("pz_resume_letter", 32'(letter), 1);
        cyc(9);
        chk("pz_addr_before", 32'(score_addr), 0);
        cyc(1);
        chk("pz_addr_after", 32'(score_addr), 1);
        pulse(3);

        // tempo 2: 4-cycle steps, 2 sounding then 2 silent
        tempo = 2'd2;
        pulse(1);
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            chk($sformatf("t2_letter%0d", i), 32'(letter), tlet[i]);
        end
        chk("t2_addr", 32'(score_addr), 1);
        pulse(3);
        tempo = 2'd0;

        // divisor table across letters and octaves
        last_half = 0;
        for (int i = 0; i < 8; i++) begin
            rom_l[0] = 4'(dvec[i].l);
            rom_o[0] = 2'(dvec[i].o);
            rom_l[1] = 4'd15;
            pulse(1);
            cyc(1);
            chk($sformatf("dv%0d_letter", i), 32'(letter), dvec[i].l);
            chk($sformatf("dv%0d_right", i), 32'(note_div_right), dvec[i].half - 1);
            chk($sformatf("dv%0d_left", i), 32'(note_div_left), left_exp(dvec[i].half));
            last_half = dvec[i].half;
            pulse(3);
        end
        chk("stop_div_hold", 32'(note_div_right), last_half - 1);

        // letter 9 is a rest: silent and divisors hold
        rom_l[0] = 4'd9;
        rom_o[0] = 2'd1;
        pulse(1);
        cyc(1);
        chk("rest_letter", 32'(letter), 0);
        chk("rest_div_r", 32'(note_div_right), last_half - 1);
        chk("rest_div_l", 32'(note_div_left), left_exp(last_half));
        pulse(3);

        // asynchronous reset mid-play
        rom_default();
        pulse(1);
        cyc(20);
        chk("ar_pre_div", 32'(note_div_right), 127550);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_addr", 32'(score_addr), 0);
        chk("ar_div_r", 32'(note_div_right), 191109);
        chk("ar_div_l", 32'(note_div_left), 191109);
        chk("ar_letter", 32'(letter), 0);
        chk("ar_playing", 32'(playing), 0);
        chk("ar_done", 32'(done), 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
